safety_island_obi_sbr_mem: RTL and testbench

// - OBI subordinate (responder) SRAM. It is the far end of the DMA's OBI manager ports and of the rready converter.
// - Accepts OBI A-channel requests and performs word read/write on an internal register array.
// - Returns R-channel responses through a credit-limited response FIFO that honours manager backpressure (rready_i).
// - Used as DMA target/scratch memory on the safety island interconnect.

---
 rtl/safety_island_obi_sbr_mem.sv | 123 ++++++++++++
 tb/tb_safety_island_obi_sbr_mem.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safety_island_obi_sbr_mem.sv
// OBI subordinate SRAM: word read/write on a register array, with responses returned
// through a credit-limited FIFO that honours R-channel backpressure.
module safety_island_obi_sbr_mem #(
  parameter int unsigned           AddrWidth = 32,
  parameter int unsigned           DataWidth = 32,
  parameter int unsigned           IdWidth   = 1,
  parameter int unsigned           NumWords  = 256,
  parameter logic [AddrWidth-1:0]  BaseAddr  = '0,
  parameter int unsigned           Depth     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IdWidth-1:0]     aid_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IdWidth-1:0]     rid_o,
  output logic                   err_o
);

  localparam int unsigned Bytes = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(Bytes);
  localparam int unsigned IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;

  // Range check is done one bit wider than the address so the limit cannot wrap.
  localparam logic [AddrWidth:0] BaseExt  = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0] SpanExt  = (AddrWidth + 1)'(NumWords * Bytes);
  localparam logic [AddrWidth:0] LimitExt = BaseExt + SpanExt;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic [DataWidth-1:0] fifo_data_q [Depth];
  logic [IdWidth-1:0]   fifo_id_q   [Depth];
  logic                 fifo_err_q  [Depth];

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] outs_q, outs_d;

  logic [AddrWidth:0]   addr_ext;
  logic [AddrWidth:0]   offset;
  logic [IdxW-1:0]      idx;
  logic                 in_range;
  logic                 accept;
  logic                 pop;
  logic [DataWidth-1:0] resp_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  always_comb begin
    addr_ext  = {1'b0, addr_i};
    offset    = addr_ext - BaseExt;
    idx       = IdxW'(offset >> OffW);
    in_range  = (addr_ext >= BaseExt) && (addr_ext < LimitExt);
    resp_data = (in_range && !we_i) ? mem_q[idx] : '0;
  end

  // Grant depends only on registered credit state, never on req_i or rready_i.
  assign gnt_o    = !rst_i && (outs_q < CntW'(Depth));
  assign accept   = req_i && gnt_o;
  assign rvalid_o = (outs_q != '0);
  assign pop      = rvalid_o && rready_i;

  assign rdata_o = rvalid_o ? fifo_data_q[rptr_q] : '0;
  assign rid_o   = rvalid_o ? fifo_id_q[rptr_q]   : '0;
  assign err_o   = rvalid_o ? fifo_err_q[rptr_q]  : 1'b0;

  always_comb begin
    outs_d = outs_q;
    unique case ({accept, pop})
      2'b10:   outs_d = outs_q + 1'b1;
      2'b01:   outs_d = outs_q - 1'b1;
      default: outs_d = outs_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int k = 0; k < Bytes; k++) begin
        if (be_i[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_data_q[wptr_q] <= resp_data;
      fifo_id_q[wptr_q]   <= aid_i;
      fifo_err_q[wptr_q]  <= !in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outs_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      outs_q <= outs_d;
      if (accept) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
    end
  end

endmodule

// File: tb/tb_safety_island_obi_sbr_mem.sv
// Directed bench for the OBI subordinate SRAM: byte enables, range errors, backpressure,
// sustained throughput and reset with pending responses.
module tb_safety_island_obi_sbr_mem;

  localparam logic [31:0] Base = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        aid;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rid;
  logic        err;

  int checks   = 0;
  int failures = 0;

  safety_island_obi_sbr_mem #(
    .AddrWidth(32),
    .DataWidth(32),
    .IdWidth  (1),
    .NumWords (16),
    .BaseAddr (Base),
    .Depth    (2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .gnt_o   (gnt),
    .addr_i  (addr),
    .we_i    (we),
    .be_i    (be),
    .wdata_i (wdata),
    .aid_i   (aid),
    .rvalid_o(rvalid),
    .rready_i(rready),
    .rdata_o (rdata),
    .rid_o   (rid),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  // Hold a request until granted (bounded), return 1 ns after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic id);
    int n;
    req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = id;
    n = 0;
    @(negedge clk);
    while (!gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt !== 1'b1) begin
      failures++;
      $display("FAIL issue_grant addr=%h got gnt=%b want 1", a, gnt);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic pop_one();
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 1'b0) begin
      failures++; $display("FAIL reset_gnt got %b want 0", gnt);
    end
    checks++;
    if ({rvalid, rid, err, rdata} !== 35'd0) begin
      failures++;
      $display("FAIL reset_r got v=%b id=%b e=%b d=%h want all 0", rvalid, rid, err, rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin
      failures++; $display("FAIL reset_release_gnt got %b want 1", gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    issue(1'b1, Base + 32'd4, 4'hF, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checks++;
    if ({rvalid, rid, err, rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL wr_resp got v=%b id=%b e=%b d=%h want 1 0 0 0",
                           rvalid, rid, err, rdata);
    end
    pop_one();
    issue(1'b0, Base + 32'd4, 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if ({rvalid, rid, err, rdata} !== {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL rd_resp got v=%b id=%b e=%b d=%h want 1 1 0 deadbeef",
                           rvalid, rid, err, rdata);
    end
    pop_one();
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL rd_drained got rvalid=%b want 0", rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_enable();
    issue(1'b1, Base + 32'd8, 4'hF, 32'hFFFF_FFFF, 1'b0);
    pop_one();
    issue(1'b1, Base + 32'd8, 4'b0101, 32'h1122_3344, 1'b0);
    pop_one();
    issue(1'b1, Base + 32'd8, 4'h0, 32'h0000_0000, 1'b0);
    pop_one();
    issue(1'b0, Base + 32'd8, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'hFF22_FF44}) begin
      failures++; $display("FAIL byte_enable got v=%b e=%b d=%h want 1 0 ff22ff44",
                           rvalid, err, rdata);
    end
    pop_one();
  endtask

  task automatic test_range();
    logic [31:0] a [6];
    logic        w [6];
    logic [34:0] exp [6];
    a[0] = Base + 32'd60; w[0] = 1'b1; exp[0] = {1'b1, 1'b0, 1'b0, 32'h0};
    a[1] = Base + 32'd64; w[1] = 1'b0; exp[1] = {1'b1, 1'b1, 1'b1, 32'h0};
    a[2] = Base - 32'd4;  w[2] = 1'b0; exp[2] = {1'b1, 1'b0, 1'b1, 32'h0};
    a[3] = Base - 32'd4;  w[3] = 1'b1; exp[3] = {1'b1, 1'b1, 1'b1, 32'h0};
    a[4] = Base + 32'd72; w[4] = 1'b1; exp[4] = {1'b1, 1'b0, 1'b1, 32'h0};
    a[5] = Base + 32'd62; w[5] = 1'b0; exp[5] = {1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5};
    for (int i = 0; i < 6; i++) begin
      issue(w[i], a[i], 4'hF, (i == 0) ? 32'hA5A5_A5A5 : 32'h0, 1'(i % 2));
      @(negedge clk);
      checks++;
      if ({rvalid, rid, err, rdata} !== exp[i]) begin
        failures++; $display("FAIL range_%0d addr=%h got %h want %h", i, a[i],
                             {rvalid, rid, err, rdata}, exp[i]);
      end
      pop_one();
    end
    // Out-of-range writes above must not have aliased onto word 2.
    issue(1'b0, Base + 32'd8, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (rdata !== 32'hFF22_FF44) begin
      failures++; $display("FAIL range_neighbour got %h want ff22ff44", rdata);
    end
    pop_one();
  endtask

  task automatic test_backpressure();
    rready = 1'b0;
    req = 1'b1; we = 1'b0; be = 4'hF; wdata = '0;
    addr = Base + 32'd4; aid = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin failures++; $display("FAIL bp_gnt0 got %b want 1", gnt); end
    @(posedge clk); #1;
    addr = Base + 32'd8; aid = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin failures++; $display("FAIL bp_gnt1 got %b want 1", gnt); end
    @(posedge clk); #1;
    addr = Base + 32'd60; aid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rready = 1'b1;
      @(negedge clk);
      checks++;
      if ({gnt, rvalid, rid, err, rdata} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
        failures++; $display("FAIL bp_stall_%0d got g=%b v=%b id=%b e=%b d=%h want 0 1 0 0 deadbeef",
                             c, gnt, rvalid, rid, err, rdata);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, rid, err, rdata} !== {1'b1, 1'b1, 1'b1, 1'b0, 32'hFF22_FF44}) begin
      failures++; $display("FAIL bp_second got g=%b v=%b id=%b e=%b d=%h want 1 1 1 0 ff22ff44",
                           gnt, rvalid, rid, err, rdata);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid, rid, err, rdata} !== {1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5}) begin
      failures++; $display("FAIL bp_third got v=%b id=%b e=%b d=%h want 1 0 0 a5a5a5a5",
                           rvalid, rid, err, rdata);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL bp_drained got %b want 0", rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      rready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
        if (i < 8) begin
          req = 1'b1; we = (pass == 0); addr = Base + 32'(4 * i); be = 4'hF;
          wdata = 32'h1000_0000 + 32'(i); aid = 1'(i % 2);
        end else begin
          req = 1'b0;
        end
        @(negedge clk);
        if (i < 8) begin
          checks++;
          if (gnt !== 1'b1) begin
            failures++; $display("FAIL b2b_gnt pass=%0d i=%0d got %b want 1", pass, i, gnt);
          end
        end
        if (i > 0) begin
          exp = {1'b1, 1'((i - 1) % 2), 1'b0,
                 (pass == 0) ? 32'h0 : 32'h1000_0000 + 32'(i - 1)};
          checks++;
          if ({rvalid, rid, err, rdata} !== exp) begin
            failures++; $display("FAIL b2b_resp pass=%0d i=%0d got %h want %h", pass, i,
                                 {rvalid, rid, err, rdata}, exp);
          end
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
        failures++; $display("FAIL b2b_drained pass=%0d got %b want 0", pass, rvalid);
      end
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic test_reset_pending();
    rready = 1'b0;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = Base + 32'd4; aid = 1'b0;
    @(posedge clk); #1;
    addr = Base + 32'd8;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid} !== 2'b01) begin
      failures++; $display("FAIL rstp_full got g=%b v=%b want 0 1", gnt, rvalid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid} !== 2'b00) begin
      failures++; $display("FAIL rstp_flush got g=%b v=%b want 0 0", gnt, rvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid} !== 2'b10) begin
      failures++; $display("FAIL rstp_release got g=%b v=%b want 1 0", gnt, rvalid);
    end
    @(posedge clk); #1;
    issue(1'b0, Base + 32'd12, 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if ({rvalid, rid, err, rdata} !== {1'b1, 1'b1, 1'b0, 32'h1000_0003}) begin
      failures++; $display("FAIL rstp_mem got v=%b id=%b e=%b d=%h want 1 1 0 10000003",
                           rvalid, rid, err, rdata);
    end
    pop_one();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; aid = 1'b0;
    rready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
